// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON state-injection datapath.
//   type_state  : 5 x 64-bit ASCON state, index 0 is W0
//   type_xor_op : operation codes of ascon_xor_absorb (code 7 is illegal)
//   type_fsm    : control states of ascon_xor_absorb
package ascon_pack;

   typedef logic [4:0][63:0] type_state;

   typedef enum logic [2:0] {
      OP_NOP       = 3'd0,
      OP_KEY_INIT  = 3'd1,
      OP_KEY_FINAL = 3'd2,
      OP_ABSORB    = 3'd3,
      OP_ENC       = 3'd4,
      OP_DEC       = 3'd5,
      OP_DOMSEP    = 3'd6
   } type_xor_op;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StOut
   } type_fsm;

   localparam logic [7:0]  PAD_BYTE     = 8'h80;
   localparam int unsigned RATE64_BITS  = 64;
   localparam int unsigned RATE128_BITS = 128;

   // Block counter increment that sticks at all-ones.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ascon_pad_mask.sv
// Combinational padding / byte-mask generator for one rate block.
// Byte k (k=0 is the MSB byte) is valid when k < nbytes; byte nbytes carries the
// 0x80 pad unless the block is full. nbytes above the rate size is clamped to full.
//   data_i    : raw block, MSB byte first
//   nbytes_i  : number of valid bytes
//   padded_o  : valid bytes, pad byte, zeros elsewhere
//   valid_o   : per-byte valid flags, bit k = byte k
//   pad_o     : per-byte pad-position flag (at most one bit set)
module ascon_pad_mask
   import ascon_pack::*;
#(
   parameter int unsigned RATE_BITS = RATE128_BITS,
   parameter int unsigned NB_W      = $clog2(RATE_BITS / 8 + 1)
) (
   input  logic [RATE_BITS-1:0]   data_i,
   input  logic [NB_W-1:0]        nbytes_i,
   output logic [RATE_BITS-1:0]   padded_o,
   output logic [RATE_BITS/8-1:0] valid_o,
   output logic [RATE_BITS/8-1:0] pad_o
);

   localparam int unsigned NumBytes = RATE_BITS / 8;

   logic [NB_W-1:0] nb_clamped;

   always_comb begin
      nb_clamped = nbytes_i;
      if (nbytes_i > NB_W'(NumBytes)) begin
         nb_clamped = NB_W'(NumBytes);
      end
   end

   always_comb begin
      padded_o = '0;
      valid_o  = '0;
      pad_o    = '0;
      for (int k = 0; k < NumBytes; k++) begin
         valid_o[k] = (NB_W'(k) < nb_clamped);
         // A full block never matches here since k stops at NumBytes-1.
         pad_o[k]   = (NB_W'(k) == nb_clamped);
         if (valid_o[k]) begin
            padded_o[RATE_BITS-1-8*k -: 8] = data_i[RATE_BITS-1-8*k -: 8];
         end else if (pad_o[k]) begin
            padded_o[RATE_BITS-1-8*k -: 8] = PAD_BYTE;
         end
      end
   end

endmodule

// File: rtl/ascon_xor_absorb.sv
// Registered ASCON state-injection unit: key injection, AD absorption, domain
// separation, and encryption/decryption with in-block padding.
// Optional feature macro: ASCON_DEC_EN (when undefined, OP_DEC is an illegal code and
// the decrypt datapath is absent).
// Ports:
//   clock_i, resetb_i       : clock, asynchronous active-low reset
//   start_i / ready_o       : request handshake, accepted in idle only
//   op_i, state_i, data_i,
//   nbytes_i, key_i         : operands, captured at accept
//   state_o, data_o         : registered results
//   data_valid_o, done_o    : completion pulses (data_valid_o for ENC/DEC)
//   err_o                   : sticky illegal-op flag, cleared by OP_KEY_INIT
//   blk_cnt_o               : saturating rate-block counter since OP_KEY_INIT
module ascon_xor_absorb
   import ascon_pack::*;
#(
   parameter int unsigned RATE_BITS = RATE128_BITS,
   parameter int unsigned NB_W      = $clog2(RATE_BITS / 8 + 1)
) (
   input  logic                 clock_i,
   input  logic                 resetb_i,
   input  logic                 start_i,
   output logic                 ready_o,
   input  logic [2:0]           op_i,
   input  type_state            state_i,
   input  logic [RATE_BITS-1:0] data_i,
   input  logic [NB_W-1:0]      nbytes_i,
   input  logic [127:0]         key_i,
   output type_state            state_o,
   output logic [RATE_BITS-1:0] data_o,
   output logic                 data_valid_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [15:0]          blk_cnt_o
);

   localparam int unsigned NumBytes = RATE_BITS / 8;

   if (!(RATE_BITS == RATE64_BITS || RATE_BITS == RATE128_BITS)) begin : g_bad_rate
      $error("ascon_xor_absorb: RATE_BITS must be 64 or 128");
   end
   if (NB_W != $clog2(RATE_BITS / 8 + 1)) begin : g_bad_nbw
      $error("ascon_xor_absorb: NB_W is derived and must not be overridden");
   end

   type_fsm              fsm_q, fsm_d;
   logic [2:0]           op_q, op_d;
   type_state            st_in_q, st_in_d;
   logic [RATE_BITS-1:0] data_in_q, data_in_d;
   logic [NB_W-1:0]      nb_in_q, nb_in_d;
   logic [127:0]         key_q, key_d;
   type_state            state_q, state_d;
   logic [RATE_BITS-1:0] data_q, data_d;
   logic                 dv_q, dv_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [15:0]          blk_q, blk_d;

   logic [RATE_BITS-1:0] padded;
   logic [NumBytes-1:0]  valid_mask;
   logic [NumBytes-1:0]  pad_mask;
   logic [RATE_BITS-1:0] vmask;
   logic [RATE_BITS-1:0] old_rate;
   logic [RATE_BITS-1:0] absorb_rate;
   logic [RATE_BITS-1:0] new_rate;
   type_state            st_rate;

   ascon_pad_mask #(
      .RATE_BITS (RATE_BITS),
      .NB_W      (NB_W)
   ) u_pad_mask (
      .data_i   (data_in_q),
      .nbytes_i (nb_in_q),
      .padded_o (padded),
      .valid_o  (valid_mask),
      .pad_o    (pad_mask)
   );

   // Byte flags expanded to a bit mask for data_o.
   always_comb begin
      vmask = '0;
      for (int k = 0; k < NumBytes; k++) begin
         vmask[RATE_BITS-1-8*k -: 8] = {8{valid_mask[k]}};
      end
   end

   // Rate words: W0 holds the first 8 bytes, W1 the next 8 for the 128-bit rate.
   if (RATE_BITS == RATE128_BITS) begin : g_rate128
      assign old_rate = {st_in_q[0], st_in_q[1]};
      always_comb begin
         st_rate    = st_in_q;
         st_rate[0] = new_rate[127:64];
         st_rate[1] = new_rate[63:0];
      end
   end else begin : g_rate64
      assign old_rate = st_in_q[0];
      always_comb begin
         st_rate    = st_in_q;
         st_rate[0] = new_rate;
      end
   end

   assign absorb_rate = old_rate ^ padded;

`ifdef ASCON_DEC_EN
   // Valid bytes take the ciphertext, the pad byte flips 0x80, the tail is kept.
   logic [RATE_BITS-1:0] dec_rate;

   always_comb begin
      dec_rate = old_rate;
      for (int k = 0; k < NumBytes; k++) begin
         if (valid_mask[k]) begin
            dec_rate[RATE_BITS-1-8*k -: 8] = data_in_q[RATE_BITS-1-8*k -: 8];
         end else if (pad_mask[k]) begin
            dec_rate[RATE_BITS-1-8*k -: 8] = old_rate[RATE_BITS-1-8*k -: 8] ^ PAD_BYTE;
         end
      end
   end
`else
   logic unused_pad;
   assign unused_pad = ^pad_mask;
`endif

   always_comb begin
      new_rate = absorb_rate;
`ifdef ASCON_DEC_EN
      if (op_q == OP_DEC) begin
         new_rate = dec_rate;
      end
`endif
   end

   always_comb begin
      fsm_d     = fsm_q;
      op_d      = op_q;
      st_in_d   = st_in_q;
      data_in_d = data_in_q;
      nb_in_d   = nb_in_q;
      key_d     = key_q;
      state_d   = state_q;
      data_d    = data_q;
      dv_d      = 1'b0;
      done_d    = 1'b0;
      err_d     = err_q;
      blk_d     = blk_q;

      unique case (fsm_q)
         StIdle: begin
            if (start_i) begin
               op_d      = op_i;
               st_in_d   = state_i;
               data_in_d = data_i;
               nb_in_d   = nbytes_i;
               key_d     = key_i;
               fsm_d     = StCalc;
            end
         end
         StCalc: begin
            fsm_d   = StOut;
            done_d  = 1'b1;
            state_d = st_in_q;
            case (op_q)
               OP_NOP: begin
               end
               OP_KEY_INIT: begin
                  state_d[3] = st_in_q[3] ^ key_q[127:64];
                  state_d[4] = st_in_q[4] ^ key_q[63:0];
                  blk_d      = '0;
                  err_d      = 1'b0;
               end
               OP_KEY_FINAL: begin
                  if (RATE_BITS == RATE64_BITS) begin
                     state_d[1] = st_in_q[1] ^ key_q[127:64];
                     state_d[2] = st_in_q[2] ^ key_q[63:0];
                  end else begin
                     state_d[2] = st_in_q[2] ^ key_q[127:64];
                     state_d[3] = st_in_q[3] ^ key_q[63:0];
                  end
               end
               OP_DOMSEP: begin
                  state_d[4] = st_in_q[4] ^ 64'h1;
               end
               OP_ABSORB: begin
                  state_d = st_rate;
                  blk_d   = sat_inc(blk_q);
               end
               OP_ENC: begin
                  state_d = st_rate;
                  data_d  = absorb_rate & vmask;
                  dv_d    = 1'b1;
                  blk_d   = sat_inc(blk_q);
               end
`ifdef ASCON_DEC_EN
               OP_DEC: begin
                  state_d = st_rate;
                  data_d  = (old_rate ^ data_in_q) & vmask;
                  dv_d    = 1'b1;
                  blk_d   = sat_inc(blk_q);
               end
`endif
               default: begin
                  // Illegal codes pass the state through and flag the error.
                  err_d = 1'b1;
               end
            endcase
         end
         StOut: begin
            fsm_d = StIdle;
         end
         default: begin
            fsm_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         fsm_q     <= StIdle;
         op_q      <= '0;
         st_in_q   <= '0;
         data_in_q <= '0;
         nb_in_q   <= '0;
         key_q     <= '0;
         state_q   <= '0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         blk_q     <= '0;
      end else begin
         fsm_q     <= fsm_d;
         op_q      <= op_d;
         st_in_q   <= st_in_d;
         data_in_q <= data_in_d;
         nb_in_q   <= nb_in_d;
         key_q     <= key_d;
         state_q   <= state_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         done_q    <= done_d;
         err_q     <= err_d;
         blk_q     <= blk_d;
      end
   end

   assign ready_o      = (fsm_q == StIdle);
   assign state_o      = state_q;
   assign data_o       = data_q;
   assign data_valid_o = dv_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign blk_cnt_o    = blk_q;

endmodule
